// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the ALU command sequencer.
//   opcode_t    : command opcodes accepted on cmd_op
//   alu_op_t    : operation codes driven to the external ALU
//   state_t     : sequencer state encoding
//   flag_bit_t  : bit positions inside the flag register
//   alu_op_of() : maps a command opcode onto the ALU operation it uses
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_ADC = 3'b001,
        OP_SUB = 3'b010,
        OP_SBB = 3'b011,
        OP_ANA = 3'b100,
        OP_CMP = 3'b101,
        OP_LDA = 3'b110,
        OP_DAA = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,   // add with carry-in
        ALU_SUB = 2'b01,   // subtract with borrow-in
        ALU_AND = 2'b10,
        ALU_CMP = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DAA2 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        FLAG_CY = 3'd0,
        FLAG_P  = 3'd2,
        FLAG_AC = 3'd4,
        FLAG_Z  = 3'd6,
        FLAG_S  = 3'd7
    } flag_bit_t;

    // LDA has no ALU work to do; it reports the idle/AND code.
    function automatic alu_op_t alu_op_of(input opcode_t op);
        case (op)
            OP_ADD, OP_ADC, OP_DAA: return ALU_ADD;
            OP_SUB, OP_SBB:         return ALU_SUB;
            OP_CMP:                 return ALU_CMP;
            default:                return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_daa_corr.sv
// alu_seq_daa_corr -- decimal-adjust correction constants.
//   acc     : accumulator value the correction is judged on
//   ac, cy  : auxiliary-carry and carry flags
//   corr_lo : 06h when the low nibble needs adjusting, else 00h
//   corr_hi : 60h when the high nibble needs adjusting, else 00h
// Purely combinational; the sequencer applies corr_lo in its first pass
// (judged on the original accumulator) and corr_hi in the second pass
// (judged on the low-corrected accumulator and the original carry).
module alu_seq_daa_corr #(
    parameter int DATASIZE = 8
) (
    input  logic [DATASIZE-1:0] acc,
    input  logic                ac,
    input  logic                cy,
    output logic [DATASIZE-1:0] corr_lo,
    output logic [DATASIZE-1:0] corr_hi
);

    assign corr_lo = (acc[3:0] > 4'd9 || ac) ? DATASIZE'(8'h06) : '0;
    assign corr_hi = (acc[7:4] > 4'd9 || cy) ? DATASIZE'(8'h60) : '0;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer -- sequences single accumulator commands through an
// external ALU and holds the accumulator and flag register.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_op, cmd_operand : opcode and B operand / load value
//   alu_op, alu_a/b/f   : operation, operands and flags-in to the ALU
//   alu_r, alu_fo       : ALU result and flags-out
//   acc_out, flags_out  : accumulator and flag register
//   done, err           : one-cycle completion / unsupported-opcode pulses
// Build option: define ALU_SEQ_DAA_EN to support DAA as a two-pass add.
// Without it DAA completes immediately with err and changes nothing.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [DATASIZE-1:0] cmd_operand,
    output logic [1:0]          alu_op,
    output logic [DATASIZE-1:0] alu_a,
    output logic [DATASIZE-1:0] alu_b,
    output logic [DATASIZE-1:0] alu_f,
    input  logic [DATASIZE-1:0] alu_r,
    input  logic [DATASIZE-1:0] alu_fo,
    output logic [DATASIZE-1:0] acc_out,
    output logic [DATASIZE-1:0] flags_out,
    output logic                done,
    output logic                err
);

    state_t              state_reg, state_next;
    opcode_t             op_reg;
    logic [DATASIZE-1:0] operand_reg;
    logic [DATASIZE-1:0] acc_reg, acc_next;
    logic [DATASIZE-1:0] flags_reg, flags_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                accept;

`ifdef ALU_SEQ_DAA_EN
    logic                daa_c1_reg, daa_c1_next;   // carry out of pass 1
    logic [DATASIZE-1:0] daa_corr_lo, daa_corr_hi;

    alu_seq_daa_corr #(
        .DATASIZE (DATASIZE)
    ) u_daa_corr (
        .acc     (acc_reg),
        .ac      (flags_reg[FLAG_AC]),
        .cy      (flags_reg[FLAG_CY]),
        .corr_lo (daa_corr_lo),
        .corr_hi (daa_corr_hi)
    );
`endif

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign acc_out   = acc_reg;
    assign flags_out = flags_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_ADD;
            operand_reg <= '0;
            acc_reg     <= '0;
            flags_reg   <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
`ifdef ALU_SEQ_DAA_EN
            daa_c1_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            flags_reg   <= flags_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
`ifdef ALU_SEQ_DAA_EN
            daa_c1_reg  <= daa_c1_next;
`endif
            if (accept) begin
                op_reg      <= opcode_t'(cmd_op);
                operand_reg <= cmd_operand;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        flags_next  = flags_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        alu_op      = ALU_AND;
        alu_a       = '0;
        alu_b       = '0;
        alu_f       = '0;
`ifdef ALU_SEQ_DAA_EN
        daa_c1_next = daa_c1_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
`ifndef ALU_SEQ_DAA_EN
                    if (opcode_t'(cmd_op) == OP_DAA) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else
`endif
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_op     = alu_op_of(op_reg);
                alu_a      = acc_reg;
                alu_b      = operand_reg;
                alu_f      = flags_reg;
                state_next = ST_DONE;
                done_next  = 1'b1;
                case (op_reg)
                    OP_ADD, OP_SUB: begin
                        alu_f[FLAG_CY] = 1'b0;
                        acc_next       = alu_r;
                        flags_next     = alu_fo;
                    end
                    OP_ADC, OP_SBB, OP_ANA: begin
                        acc_next   = alu_r;
                        flags_next = alu_fo;
                    end
                    OP_CMP: flags_next = alu_fo;
                    OP_LDA: acc_next   = operand_reg;
`ifdef ALU_SEQ_DAA_EN
                    OP_DAA: begin
                        // Low-nibble pass: keep the original CY in the flag
                        // register so the high-nibble pass can still see it.
                        alu_b              = daa_corr_lo;
                        alu_f[FLAG_CY]     = 1'b0;
                        acc_next           = alu_r;
                        flags_next[FLAG_AC] = alu_fo[FLAG_AC];
                        daa_c1_next        = alu_fo[FLAG_CY];
                        state_next         = ST_DAA2;
                        done_next          = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end

`ifdef ALU_SEQ_DAA_EN
            ST_DAA2: begin
                alu_op         = ALU_ADD;
                alu_a          = acc_reg;
                alu_b          = daa_corr_hi;
                alu_f          = flags_reg;
                alu_f[FLAG_CY] = 1'b0;
                // Z, S, P come from this pass; AC stays as latched by pass 1.
                flags_next          = alu_fo;
                flags_next[FLAG_AC] = flags_reg[FLAG_AC];
                flags_next[FLAG_CY] = flags_reg[FLAG_CY] | daa_c1_reg | alu_fo[FLAG_CY];
                acc_next            = alu_r;
                state_next          = ST_DONE;
                done_next           = 1'b1;
            end
`endif

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer -- self-checking bench for alu_sequencer.
// An 8080-style ALU model answers the DUT's ALU port. Each accepted command
// pushes its expected accumulator, flags, err and done latency onto a queue;
// a negedge monitor pops and compares on every done pulse.
// Define ALU_SEQ_DAA_EN for both DUT and bench to exercise the DAA build.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_operand;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_f, alu_r, alu_fo;
    logic [7:0] acc_out, flags_out;
    logic       done, err;

    alu_sequencer #(.DATASIZE(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_r       (alu_r),
        .alu_fo      (alu_fo),
        .acc_out     (acc_out),
        .flags_out   (flags_out),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Flag layout: S=7 Z=6 AC=4 P=2 CY=0, other bits zero.
    function automatic logic [7:0] mk_flags(input logic [7:0] r, input logic ac, input logic cy);
        return {r[7], (r == 8'h00), 1'b0, ac, 1'b0, ~^r, 1'b0, cy};
    endfunction

    // External ALU model: returns {result, flags-out}.
    function automatic logic [15:0] alu_calc(input logic [1:0] aop, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] f);
        logic [8:0] s;
        logic       ac;
        case (aop)
            2'b00: begin
                s  = {1'b0, a} + {1'b0, b} + {8'b0, f[0]};
                ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, f[0]}) > 5'd15;
            end
            2'b01: begin
                s  = {1'b0, a} - {1'b0, b} - {8'b0, f[0]};
                ac = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, f[0]});
            end
            2'b10: begin
                s  = {1'b0, a & b};
                ac = 1'b0;
            end
            default: begin
                s  = {1'b0, a} - {1'b0, b};
                ac = a[3:0] < b[3:0];
            end
        endcase
        return {s[7:0], mk_flags(s[7:0], ac, s[8])};
    endfunction

    assign {alu_r, alu_fo} = alu_calc(alu_op, alu_a, alu_b, alu_f);

    typedef struct {
        logic [7:0] acc;
        logic [7:0] flags;
        logic       err;
        int         lat;
        int         t_acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_acc, m_flags;

    // Command-level reference: updates the model registers and queues the
    // expected outcome. lat counts cycles from the accept cycle to done.
    task automatic model_push(input logic [2:0] op, input logic [7:0] b);
        exp_t       e;
        logic [15:0] rf;
        logic [7:0] lo_adj, hi_adj;
        logic [8:0] t, u;
        logic       ac1;
        e.err   = 1'b0;
        e.lat   = 2;
        e.t_acc = cyc;
        rf      = 16'h0;
        case (op)
            3'd0: rf = alu_calc(2'b00, m_acc, b, 8'h00);
            3'd1: rf = alu_calc(2'b00, m_acc, b, {7'b0, m_flags[0]});
            3'd2: rf = alu_calc(2'b01, m_acc, b, 8'h00);
            3'd3: rf = alu_calc(2'b01, m_acc, b, {7'b0, m_flags[0]});
            3'd4: rf = alu_calc(2'b10, m_acc, b, 8'h00);
            3'd5: rf = alu_calc(2'b11, m_acc, b, 8'h00);
            default: ;
        endcase
        if (op <= 3'd4) begin
            m_acc   = rf[15:8];
            m_flags = rf[7:0];
        end else if (op == 3'd5) begin
            m_flags = rf[7:0];
        end else if (op == 3'd6) begin
            m_acc = b;
        end else begin
`ifdef ALU_SEQ_DAA_EN
            lo_adj  = (m_acc[3:0] > 4'd9 || m_flags[4]) ? 8'h06 : 8'h00;
            t       = {1'b0, m_acc} + {1'b0, lo_adj};
            ac1     = ({1'b0, m_acc[3:0]} + {1'b0, lo_adj[3:0]}) > 5'd15;
            hi_adj  = (t[7:4] > 4'd9 || m_flags[0]) ? 8'h60 : 8'h00;
            u       = {1'b0, t[7:0]} + {1'b0, hi_adj};
            m_flags = mk_flags(u[7:0], ac1, m_flags[0] | t[8] | u[8]);
            m_acc   = u[7:0];
            e.lat   = 3;
`else
            lo_adj = 8'h00; hi_adj = 8'h00; t = 9'h0; u = 9'h0; ac1 = 1'b0;
            e.err  = 1'b1;
            e.lat  = 1;
`endif
        end
        e.acc   = m_acc;
        e.flags = m_flags;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: one line per completed transaction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst !== 1'b1 && done === 1'b1) begin
            check_eq("done_has_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("txn: acc=%02h flags=%02h err=%0d lat=%0d", acc_out, flags_out, err, cyc - e.t_acc);
                check_eq("sb_acc", {24'b0, acc_out}, {24'b0, e.acc});
                check_eq("sb_flags", {24'b0, flags_out}, {24'b0, e.flags});
                check_eq("sb_err", {31'b0, err}, {31'b0, e.err});
                check_eq("sb_latency", cyc - e.t_acc, e.lat);
            end
        end else if (rst !== 1'b1 && err === 1'b1) begin
            check_eq("err_without_done", {31'b0, err}, 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] op, input logic [7:0] b);
        bit ok;
        ok          = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_ready === 1'b1) begin
                model_push(op, b);
                ok = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (i >= 20) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_acc   = 8'h00;
        m_flags = 8'h00;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        bit ok;
        // Reset with a command already valid: reset must win.
        rst         = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = 3'd6;
        cmd_operand = 8'h77;
        m_acc       = 8'h00;
        m_flags     = 8'h00;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        check_eq("rst_acc", {24'b0, acc_out}, 32'h00);
        check_eq("rst_flags", {24'b0, flags_out}, 32'h00);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check_eq("idle_alu_op", {30'b0, alu_op}, 32'd2);
        check_eq("idle_alu_a", {24'b0, alu_a}, 32'h00);

        // LDA 3Ah
        send(3'd6, 8'h3A);
        wait_idle();
        check_eq("lda_acc", {24'b0, acc_out}, 32'h3A);
        check_eq("lda_flags", {24'b0, flags_out}, 32'h00);
        check_eq("idle2_alu_op", {30'b0, alu_op}, 32'd2);
        check_eq("idle2_alu_a", {24'b0, alu_a}, 32'h00);
        check_eq("idle2_alu_b", {24'b0, alu_b}, 32'h00);
        check_eq("idle2_alu_f", {24'b0, alu_f}, 32'h00);

        // Build acc=FFh with CY=1, then ADD 01h (carry-in must be cleared).
        send(3'd6, 8'h00); wait_idle();
        send(3'd2, 8'h01); wait_idle();
        check_eq("sub_acc", {24'b0, acc_out}, 32'hFF);
        check_eq("sub_cy", {31'b0, flags_out[0]}, 32'd1);
        send(3'd0, 8'h01);
        check_eq("add_busy_ready", {31'b0, cmd_ready}, 32'd0);
        check_eq("add_alu_op", {30'b0, alu_op}, 32'd0);
        check_eq("add_alu_a", {24'b0, alu_a}, 32'hFF);
        check_eq("add_alu_b", {24'b0, alu_b}, 32'h01);
        check_eq("add_alu_f_cy", {31'b0, alu_f[0]}, 32'd0);
        wait_idle();
        check_eq("add_acc", {24'b0, acc_out}, 32'h00);
        check_eq("add_z", {31'b0, flags_out[6]}, 32'd1);
        check_eq("add_cy", {31'b0, flags_out[0]}, 32'd1);

        // ADC 01h from acc=FFh, CY=1 (LDA leaves flags alone).
        send(3'd6, 8'hFF); wait_idle();
        send(3'd1, 8'h01);
        check_eq("adc_alu_f_cy", {31'b0, alu_f[0]}, 32'd1);
        wait_idle();
        check_eq("adc_acc", {24'b0, acc_out}, 32'h01);

        // CMP 05h with cmd_valid held: next command (ANA 0Fh) accepted 3 cycles on.
        send(3'd6, 8'h05); wait_idle();
        cmd_valid   = 1'b1;
        cmd_op      = 3'd5;
        cmd_operand = 8'h05;
        check_eq("cmp_ready", {31'b0, cmd_ready}, 32'd1);
        model_push(3'd5, 8'h05);
        t0 = cyc;
        @(posedge clk); @(negedge clk);
        cmd_op      = 3'd4;
        cmd_operand = 8'h0F;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (cyc == t0 + 2) begin
                check_eq("cmp_done", {31'b0, done}, 32'd1);
                check_eq("cmp_acc", {24'b0, acc_out}, 32'h05);
                check_eq("cmp_z", {31'b0, flags_out[6]}, 32'd1);
            end
            if (cmd_ready === 1'b1) begin
                model_push(3'd4, 8'h0F);
                ok = 1'b1;
            end else begin
                @(posedge clk); @(negedge clk);
            end
        end
        check_eq("held_spacing", cyc - t0, 32'd3);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();

        // DAA
        do_reset(1);
`ifdef ALU_SEQ_DAA_EN
        send(3'd6, 8'h9B); wait_idle();
        send(3'd7, 8'h00); wait_idle();
        check_eq("daa_acc", {24'b0, acc_out}, 32'h01);
        check_eq("daa_cy", {31'b0, flags_out[0]}, 32'd1);
`else
        send(3'd6, 8'h42); wait_idle();
        send(3'd7, 8'h00);
        check_eq("daa_done", {31'b0, done}, 32'd1);
        check_eq("daa_err", {31'b0, err}, 32'd1);
        wait_idle();
        check_eq("daa_acc", {24'b0, acc_out}, 32'h42);
        check_eq("daa_flags", {24'b0, flags_out}, 32'h00);
`endif

        // Reset during EXEC of SUB 10h aborts the command.
        do_reset(1);
        send(3'd2, 8'h10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_acc   = 8'h00;
        m_flags = 8'h00;
        check_eq("abort_ready", {31'b0, cmd_ready}, 32'd1);
        check_eq("abort_acc", {24'b0, acc_out}, 32'h00);
        check_eq("abort_flags", {24'b0, flags_out}, 32'h00);
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_done", {31'b0, done}, 32'd0);
        end

        // Random command mix through the scoreboard.
        for (int n = 0; n < 24; n++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom));
            wait_idle();
        end

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
